// File: rtl/lockstep_alu_checker.sv
// Dual-lane lockstep ALU with registered results, an XOR divergence checker,
// a saturating mismatch counter and an OK/WARN/FAULT health FSM.
module lockstep_alu_checker #(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 8,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    input  logic [1:0]       ALU_Sel1,
    input  logic [1:0]       ALU_Sel2,
    input  logic             clr_err,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALU_Out1,
    output logic [WIDTH-1:0] ALU_Out2,
    output logic             CarryOut1,
    output logic             CarryOut2,
    output logic [WIDTH-1:0] x,
    output logic             y,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_OK    = 2'b00,
        ST_WARN  = 2'b01,
        ST_FAULT = 2'b10
    } health_e;

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Result is {carry/borrow, value}; sub borrow is bit WIDTH of the zero-extended difference.
    function automatic logic [WIDTH:0] alu_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [1:0]       sel);
        logic [WIDTH:0] r;
        case (sel)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {1'b0, a} - {1'b0, b};
            2'b10:   r = {1'b0, a & b};
            default: r = {1'b0, a | b};
        endcase
        return r;
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_out1_q, alu_out1_d;
    logic [WIDTH-1:0] alu_out2_q, alu_out2_d;
    logic             carry1_q, carry1_d;
    logic             carry2_q, carry2_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             err_sticky_q, err_sticky_d;
    health_e          state_q, state_d;

    logic [WIDTH:0]   lane1_res, lane2_res;
    logic [CNT_W-1:0] cnt_base;
    logic             sticky_base;
    health_e          state_base;
    logic             mismatch_w;

    assign lane1_res  = alu_op(A0, B0, ALU_Sel1);
    assign lane2_res  = alu_op(A1, B1, ALU_Sel2);
    assign mismatch_w = out_valid_q & ((|(alu_out1_q ^ alu_out2_q)) | (carry1_q ^ carry2_q));

    always_comb begin
        out_valid_d = in_valid;
        alu_out1_d  = alu_out1_q;
        alu_out2_d  = alu_out2_q;
        carry1_d    = carry1_q;
        carry2_d    = carry2_q;
        if (in_valid) begin
            alu_out1_d = lane1_res[WIDTH-1:0];
            carry1_d   = lane1_res[WIDTH];
            alu_out2_d = lane2_res[WIDTH-1:0];
            carry2_d   = lane2_res[WIDTH];
        end
    end

    // clr_err wipes history first, then a same-edge mismatch is applied on top.
    always_comb begin
        cnt_base    = clr_err ? '0 : err_count_q;
        sticky_base = clr_err ? 1'b0 : err_sticky_q;
        state_base  = clr_err ? ST_OK : state_q;

        err_count_d = cnt_base;
        if (mismatch_w && (cnt_base != CNT_MAX)) begin
            err_count_d = cnt_base + 1'b1;
        end
        err_sticky_d = sticky_base | mismatch_w;

        state_d = state_base;
        case (state_base)
            ST_OK: begin
                if (mismatch_w) begin
                    state_d = (err_count_d >= THRESH_C) ? ST_FAULT : ST_WARN;
                end
            end
            ST_WARN: begin
                if (err_count_d >= THRESH_C) begin
                    state_d = ST_FAULT;
                end
            end
            default: state_d = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            alu_out1_q   <= '0;
            alu_out2_q   <= '0;
            carry1_q     <= 1'b0;
            carry2_q     <= 1'b0;
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
            state_q      <= ST_OK;
        end else begin
            out_valid_q  <= out_valid_d;
            alu_out1_q   <= alu_out1_d;
            alu_out2_q   <= alu_out2_d;
            carry1_q     <= carry1_d;
            carry2_q     <= carry2_d;
            err_count_q  <= err_count_d;
            err_sticky_q <= err_sticky_d;
            state_q      <= state_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign ALU_Out1   = alu_out1_q;
    assign ALU_Out2   = alu_out2_q;
    assign CarryOut1  = carry1_q;
    assign CarryOut2  = carry2_q;
    assign x          = alu_out1_q ^ alu_out2_q;
    assign y          = carry1_q ^ carry2_q;
    assign mismatch   = mismatch_w;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;
    assign state      = state_q;

endmodule

// File: tb/tb_lockstep_alu_checker.sv
// Bench for lockstep_alu_checker: default instance plus a CNT_W=2/THRESH=3 instance on shared stimulus.
module tb_lockstep_alu_checker;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
    logic [1:0]   ALU_Sel1 = '0, ALU_Sel2 = '0;
    logic         clr_err = 1'b0;

    logic         out_valid, CarryOut1, CarryOut2, y, mismatch, err_sticky;
    logic [W-1:0] ALU_Out1, ALU_Out2, x;
    logic [7:0]   err_count;
    logic [1:0]   state;

    logic         s_out_valid, s_CarryOut1, s_CarryOut2, s_y, s_mismatch, s_err_sticky;
    logic [W-1:0] s_ALU_Out1, s_ALU_Out2, s_x;
    logic [1:0]   s_err_count;
    logic [1:0]   s_state;

    logic [2*W+1:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int n_popped = 0;
    int mm_model = 0;

    lockstep_alu_checker #(.WIDTH(W), .CNT_W(8), .THRESH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .ALU_Sel1(ALU_Sel1), .ALU_Sel2(ALU_Sel2), .clr_err(clr_err),
        .out_valid(out_valid), .ALU_Out1(ALU_Out1), .ALU_Out2(ALU_Out2),
        .CarryOut1(CarryOut1), .CarryOut2(CarryOut2), .x(x), .y(y),
        .mismatch(mismatch), .err_sticky(err_sticky), .err_count(err_count), .state(state)
    );

    lockstep_alu_checker #(.WIDTH(W), .CNT_W(2), .THRESH(3)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .ALU_Sel1(ALU_Sel1), .ALU_Sel2(ALU_Sel2), .clr_err(clr_err),
        .out_valid(s_out_valid), .ALU_Out1(s_ALU_Out1), .ALU_Out2(s_ALU_Out2),
        .CarryOut1(s_CarryOut1), .CarryOut2(s_CarryOut2), .x(s_x), .y(s_y),
        .mismatch(s_mismatch), .err_sticky(s_err_sticky), .err_count(s_err_count), .state(s_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "timeout");
    end

    // Reference lane: {carry, value}
    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] s);
        int sum;
        case (s)
            2'b00: begin
                sum = int'(a) + int'(b);
                return {sum > 255, a + b};
            end
            2'b01:   return {a < b, a - b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    // Driver: applies inputs for one cycle; pushes the expected lane pair when a result will be captured.
    task automatic drive(input logic iv, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [1:0] s1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input logic [1:0] s2);
        logic [W:0] r1, r2;
        in_valid = iv; A0 = a0; B0 = b0; ALU_Sel1 = s1; A1 = a1; B1 = b1; ALU_Sel2 = s2;
        if (iv && !rst) begin
            r1 = ref_op(a0, b0, s1);
            r2 = ref_op(a1, b1, s2);
            exp_q.push_back({r2, r1});
            if (r1 != r2) mm_model++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle();
        idle();
        exp_q.delete();
        rst = 1'b0;
    endtask

    // Scoreboard: every registered result is compared with the oldest expected entry.
    always @(negedge clk) begin
        logic [2*W+1:0] e;
        logic [W-1:0]   ex;
        logic           ey;
        if (out_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_underflow: got out_valid=1, required no result");
            end else begin
                e  = exp_q.pop_front();
                n_popped++;
                ex = e[W-1:0] ^ e[2*W:W+1];
                ey = e[W] ^ e[2*W+1];
                if ({CarryOut2, ALU_Out2, CarryOut1, ALU_Out1} !== e || x !== ex || y !== ey
                    || mismatch !== ((|ex) | ey)) begin
                    $display("FAIL sb_result: got c2=%b o2=%h c1=%b o1=%h x=%h y=%b mm=%b, required %h x=%h y=%b",
                             CarryOut2, ALU_Out2, CarryOut1, ALU_Out1, x, y, mismatch, e, ex, ey);
                end else n_pass++;
            end
        end
    end

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({out_valid, ALU_Out1, ALU_Out2, CarryOut1, CarryOut2, x, y, mismatch} !== '0)
            $display("FAIL reset_data: got ov=%b o1=%h o2=%h c=%b%b x=%h y=%b mm=%b, required all 0",
                     out_valid, ALU_Out1, ALU_Out2, CarryOut1, CarryOut2, x, y, mismatch);
        else n_pass++;
        n_checks++;
        if (err_sticky !== 1'b0 || err_count !== 8'd0 || state !== 2'b00)
            $display("FAIL reset_health: got sticky=%b cnt=%0d st=%0d, required 0 0 0",
                     err_sticky, err_count, state);
        else n_pass++;
        n_checks++;
        if (s_err_count !== 2'd0 || s_state !== 2'b00 || s_out_valid !== 1'b0)
            $display("FAIL reset_small: got cnt=%0d st=%0d ov=%b, required 0 0 0",
                     s_err_count, s_state, s_out_valid);
        else n_pass++;
    endtask

    task automatic test_add();
        drive(1'b1, 8'h81, 8'h81, 2'b00, 8'h81, 8'h81, 2'b00);
        n_checks++;
        if (ALU_Out1 !== 8'h02 || ALU_Out2 !== 8'h02 || CarryOut1 !== 1'b1 || CarryOut2 !== 1'b1
            || x !== 8'h00 || y !== 1'b0 || mismatch !== 1'b0)
            $display("FAIL add_81: got o1=%h o2=%h c=%b%b x=%h mm=%b, required 02 02 11 00 0",
                     ALU_Out1, ALU_Out2, CarryOut1, CarryOut2, x, mismatch);
        else n_pass++;
        idle();
        n_checks++;
        if (state !== 2'b00 || err_count !== 8'd0)
            $display("FAIL add_state: got st=%0d cnt=%0d, required 0 0", state, err_count);
        else n_pass++;
    endtask

    task automatic test_sub_mismatch();
        drive(1'b1, 8'h80, 8'h00, 2'b01, 8'h00, 8'h00, 2'b01);
        n_checks++;
        if (ALU_Out1 !== 8'h80 || ALU_Out2 !== 8'h00 || x !== 8'h80 || mismatch !== 1'b1)
            $display("FAIL sub_mm: got o1=%h o2=%h x=%h mm=%b, required 80 00 80 1",
                     ALU_Out1, ALU_Out2, x, mismatch);
        else n_pass++;
        n_checks++;
        if (err_count !== 8'd0 || err_sticky !== 1'b0)
            $display("FAIL sub_cnt_latency: got cnt=%0d sticky=%b, required 0 0", err_count, err_sticky);
        else n_pass++;
        idle();
        n_checks++;
        if (err_count !== 8'd1 || err_sticky !== 1'b1 || state !== 2'b01)
            $display("FAIL sub_warn: got cnt=%0d sticky=%b st=%0d, required 1 1 1",
                     err_count, err_sticky, state);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0 || ALU_Out1 !== 8'h80 || mismatch !== 1'b0)
            $display("FAIL sub_hold: got ov=%b o1=%h mm=%b, required 0 80 0", out_valid, ALU_Out1, mismatch);
        else n_pass++;
    endtask

    task automatic test_borrow();
        clr_err = 1'b1;
        idle();
        clr_err = 1'b0;
        n_checks++;
        if (err_count !== 8'd0 || err_sticky !== 1'b0 || state !== 2'b00)
            $display("FAIL clr: got cnt=%0d sticky=%b st=%0d, required 0 0 0", err_count, err_sticky, state);
        else n_pass++;
        drive(1'b1, 8'h00, 8'h01, 2'b01, 8'h00, 8'h01, 2'b01);
        n_checks++;
        if (ALU_Out1 !== 8'hFF || CarryOut1 !== 1'b1 || CarryOut2 !== 1'b1 || mismatch !== 1'b0)
            $display("FAIL borrow: got o1=%h c=%b%b mm=%b, required ff 11 0", ALU_Out1, CarryOut1, CarryOut2, mismatch);
        else n_pass++;
        drive(1'b1, 8'hF0, 8'h0F, 2'b11, 8'hF0, 8'h0F, 2'b11);
        n_checks++;
        if (ALU_Out2 !== 8'hFF || CarryOut1 !== 1'b0 || CarryOut2 !== 1'b0)
            $display("FAIL or_ff: got o2=%h c=%b%b, required ff 00", ALU_Out2, CarryOut1, CarryOut2);
        else n_pass++;
        idle();
    endtask

    task automatic test_fault();
        for (int i = 0; i < 4; i++) drive(1'b1, 8'hFF, 8'hFF, 2'b10, 8'h00, 8'hFF, 2'b10);
        n_checks++;
        if (state !== 2'b01 || err_count !== 8'd3)
            $display("FAIL fault_pre: got st=%0d cnt=%0d, required 1 3", state, err_count);
        else n_pass++;
        idle();
        n_checks++;
        if (state !== 2'b10 || err_count !== 8'd4)
            $display("FAIL fault_enter: got st=%0d cnt=%0d, required 2 4", state, err_count);
        else n_pass++;
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h3C, 8'h0F, 2'b00, 8'h3C, 8'h0F, 2'b00);
        idle();
        n_checks++;
        if (state !== 2'b10 || err_count !== 8'd4)
            $display("FAIL fault_hold: got st=%0d cnt=%0d, required 2 4", state, err_count);
        else n_pass++;
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 6; i++) drive(1'b1, 8'h0F, 8'h0F, 2'b10, 8'h0E, 8'h0F, 2'b10);
        idle();
        n_checks++;
        if (s_err_count !== 2'd3 || s_state !== 2'b10 || err_count !== 8'd6)
            $display("FAIL sat: got s_cnt=%0d s_st=%0d cnt=%0d, required 3 2 6", s_err_count, s_state, err_count);
        else n_pass++;
        drive(1'b1, 8'h0F, 8'h0F, 2'b10, 8'h0E, 8'h0F, 2'b10);
        clr_err = 1'b1;
        idle();
        clr_err = 1'b0;
        n_checks++;
        if (s_err_count !== 2'd1 || s_state !== 2'b01 || s_err_sticky !== 1'b1
            || err_count !== 8'd1 || state !== 2'b01)
            $display("FAIL clr_mm: got s_cnt=%0d s_st=%0d s_sticky=%b cnt=%0d st=%0d, required 1 1 1 1 1",
                     s_err_count, s_state, s_err_sticky, err_count, state);
        else n_pass++;
    endtask

    task automatic test_rst_midstream();
        for (int i = 0; i < 5; i++) drive(1'b1, 8'hAA, 8'h55, 2'b11, 8'hAA, 8'h05, 2'b11);
        n_checks++;
        if (state !== 2'b10)
            $display("FAIL pre_rst_fault: got st=%0d, required 2", state);
        else n_pass++;
        rst = 1'b1;
        drive(1'b1, 8'h12, 8'h34, 2'b00, 8'h12, 8'h34, 2'b00);
        n_checks++;
        if ({out_valid, ALU_Out1, ALU_Out2, CarryOut1, CarryOut2, x, y, mismatch,
             err_sticky, err_count, state} !== '0)
            $display("FAIL rst_mid: got ov=%b o1=%h o2=%h x=%h sticky=%b cnt=%0d st=%0d, required all 0",
                     out_valid, ALU_Out1, ALU_Out2, x, err_sticky, err_count, state);
        else n_pass++;
        rst = 1'b0;
        exp_q.delete();
        drive(1'b1, 8'h12, 8'h34, 2'b00, 8'h12, 8'h34, 2'b00);
        idle();
        idle();
        n_checks++;
        if (out_valid !== 1'b0 || ALU_Out1 !== 8'h46 || ALU_Out2 !== 8'h46)
            $display("FAIL idle_hold: got ov=%b o1=%h o2=%h, required 0 46 46", out_valid, ALU_Out1, ALU_Out2);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        logic [1:0]   s;
        int start_pop;
        logic [1:0] exp_st;
        apply_reset();
        mm_model = 0;
        start_pop = n_popped;
        for (int i = 0; i < 24; i++) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                drive(1'b1, a, b, s, a, b, s);
            else
                drive(1'b1, a, b, s, W'($urandom_range(0, 255)), b, 2'($urandom_range(0, 3)));
        end
        idle();
        idle();
        n_checks++;
        if (n_popped - start_pop !== 24 || exp_q.size() != 0)
            $display("FAIL b2b_count: got %0d results (%0d left), required 24 (0 left)",
                     n_popped - start_pop, exp_q.size());
        else n_pass++;
        exp_st = (mm_model == 0) ? 2'b00 : (mm_model < 4) ? 2'b01 : 2'b10;
        n_checks++;
        if (err_count !== 8'(mm_model) || state !== exp_st || err_sticky !== (mm_model != 0))
            $display("FAIL b2b_health: got cnt=%0d st=%0d sticky=%b, required %0d %0d %0d",
                     err_count, state, err_sticky, mm_model, exp_st, mm_model != 0);
        else n_pass++;
        n_checks++;
        if (s_err_count !== 2'((mm_model > 3) ? 3 : mm_model))
            $display("FAIL b2b_small_sat: got cnt=%0d, required %0d", s_err_count, (mm_model > 3) ? 3 : mm_model);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_mismatch();
        test_borrow();
        test_fault();
        test_saturation();
        test_rst_midstream();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
